// File: rtl/arm_exe_pkg.sv
// Shared constants for the ARM EXE stage.
// Opcode encodings, NZCV bit positions and default width.
package arm_exe_pkg;

  localparam int DW_DEF = 32;

  localparam logic [3:0] EXE_MOV = 4'b0001;
  localparam logic [3:0] EXE_ADD = 4'b0010;
  localparam logic [3:0] EXE_ADC = 4'b0011;
  localparam logic [3:0] EXE_SUB = 4'b0100;
  localparam logic [3:0] EXE_SBC = 4'b0101;
  localparam logic [3:0] EXE_AND = 4'b0110;
  localparam logic [3:0] EXE_ORR = 4'b0111;
  localparam logic [3:0] EXE_EOR = 4'b1000;
  localparam logic [3:0] EXE_MVN = 4'b1001;

  localparam int FLAG_N = 3;
  localparam int FLAG_Z = 2;
  localparam int FLAG_C = 1;
  localparam int FLAG_V = 0;

endpackage

// File: rtl/arm_alu.sv
// Combinational ARM data-processing ALU.
// Arithmetic runs at DW+1 bits; the top bit is the carry.
module arm_alu
  import arm_exe_pkg::*;
#(
  parameter int DW = DW_DEF
) (
  input  logic [DW-1:0] a,
  input  logic [DW-1:0] b,
  input  logic          cin,
  input  logic [3:0]    exe_cmd,
  output logic [DW-1:0] result,
  output logic          n,
  output logic          z,
  output logic          c,
  output logic          v,
  output logic          cv_valid
);

  logic [DW:0] ea;
  logic [DW:0] eb;
  logic [DW:0] enb;
  logic [DW:0] ecin;
  logic [DW:0] one;
  logic [DW:0] sum;
  logic        sub_op;

  assign ea   = {1'b0, a};
  assign eb   = {1'b0, b};
  assign enb  = {1'b0, ~b};
  assign ecin = {{DW{1'b0}}, cin};
  assign one  = {{DW{1'b0}}, 1'b1};

  always_comb begin
    sum      = '0;
    result   = '0;
    cv_valid = 1'b0;
    sub_op   = 1'b0;
    case (exe_cmd)
      EXE_MOV: result = b;
      EXE_MVN: result = ~b;
      EXE_AND: result = a & b;
      EXE_ORR: result = a | b;
      EXE_EOR: result = a ^ b;
      EXE_ADD: begin
        sum      = ea + eb;
        cv_valid = 1'b1;
      end
      EXE_ADC: begin
        sum      = ea + eb + ecin;
        cv_valid = 1'b1;
      end
      EXE_SUB: begin
        sum      = ea + enb + one;
        cv_valid = 1'b1;
        sub_op   = 1'b1;
      end
      EXE_SBC: begin
        sum      = ea + enb + ecin;
        cv_valid = 1'b1;
        sub_op   = 1'b1;
      end
      default: result = '0;
    endcase
    if (cv_valid) result = sum[DW-1:0];
  end

  assign n = result[DW-1];
  assign z = (result == '0);
  assign c = sum[DW];

  // Overflow: operand signs (b inverted for subtract) agree, result differs
  always_comb begin
    if (sub_op)
      v = (a[DW-1] != b[DW-1]) && (result[DW-1] != a[DW-1]);
    else
      v = (a[DW-1] == b[DW-1]) && (result[DW-1] != a[DW-1]);
  end

endmodule

// File: rtl/exe_alu_stage.sv
// EXE stage: ALU, NZCV status register and EXE/MEM registers.
// Priority per edge is rst > freeze > flush > load.
module exe_alu_stage
  import arm_exe_pkg::*;
#(
  parameter int DW = DW_DEF,
  parameter int RW = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          freeze,
  input  logic          flush,
  input  logic          in_valid,
  input  logic [3:0]    exe_cmd,
  input  logic          s_bit,
  input  logic          wb_en_in,
  input  logic          mem_r_en_in,
  input  logic          mem_w_en_in,
  input  logic [RW-1:0] dest_in,
  input  logic [DW-1:0] val_1,
  input  logic [DW-1:0] val_2,
  input  logic [DW-1:0] st_val_in,
  output logic          out_valid,
  output logic [DW-1:0] alu_result,
  output logic [DW-1:0] st_val,
  output logic [RW-1:0] dest,
  output logic          wb_en,
  output logic          mem_r_en,
  output logic          mem_w_en,
  output logic [3:0]    status
);

  logic [DW-1:0] result;
  logic          n;
  logic          z;
  logic          c;
  logic          v;
  logic          cv_valid;
  logic          load;
  logic          upd;

  arm_alu #(.DW(DW)) u_alu (
    .a        (val_1),
    .b        (val_2),
    .cin      (status[FLAG_C]),
    .exe_cmd  (exe_cmd),
    .result   (result),
    .n        (n),
    .z        (z),
    .c        (c),
    .v        (v),
    .cv_valid (cv_valid)
  );

  assign load = !freeze && !flush;
  assign upd  = load && in_valid && s_bit;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid  <= 1'b0;
      alu_result <= '0;
      st_val     <= '0;
      dest       <= '0;
      wb_en      <= 1'b0;
      mem_r_en   <= 1'b0;
      mem_w_en   <= 1'b0;
    end else if (freeze) begin
      out_valid  <= out_valid;
    end else if (flush) begin
      out_valid  <= 1'b0;
      alu_result <= '0;
      st_val     <= '0;
      dest       <= '0;
      wb_en      <= 1'b0;
      mem_r_en   <= 1'b0;
      mem_w_en   <= 1'b0;
    end else begin
      out_valid  <= in_valid;
      alu_result <= result;
      st_val     <= st_val_in;
      dest       <= dest_in;
      wb_en      <= in_valid && wb_en_in;
      mem_r_en   <= in_valid && mem_r_en_in;
      mem_w_en   <= in_valid && mem_w_en_in;
    end
  end

  // C and V only move for arithmetic ops
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      status <= '0;
    end else if (upd) begin
      status[FLAG_N] <= n;
      status[FLAG_Z] <= z;
      if (cv_valid) begin
        status[FLAG_C] <= c;
        status[FLAG_V] <= v;
      end
    end
  end

endmodule

// File: tb/tb_exe_alu_stage.sv
// Directed-vector bench for exe_alu_stage.
// Expected values are hand-computed constants.
module tb_exe_alu_stage;

  logic        clk;
  logic        rst;
  logic        freeze;
  logic        flush;
  logic        in_valid;
  logic [3:0]  exe_cmd;
  logic        s_bit;
  logic        wb_en_in;
  logic        mem_r_en_in;
  logic        mem_w_en_in;
  logic [3:0]  dest_in;
  logic [31:0] val_1;
  logic [31:0] val_2;
  logic [31:0] st_val_in;
  logic        out_valid;
  logic [31:0] alu_result;
  logic [31:0] st_val;
  logic [3:0]  dest;
  logic        wb_en;
  logic        mem_r_en;
  logic        mem_w_en;
  logic [3:0]  status;

  int checks;
  int failures;

  exe_alu_stage dut (
    .clk         (clk),
    .rst         (rst),
    .freeze      (freeze),
    .flush       (flush),
    .in_valid    (in_valid),
    .exe_cmd     (exe_cmd),
    .s_bit       (s_bit),
    .wb_en_in    (wb_en_in),
    .mem_r_en_in (mem_r_en_in),
    .mem_w_en_in (mem_w_en_in),
    .dest_in     (dest_in),
    .val_1       (val_1),
    .val_2       (val_2),
    .st_val_in   (st_val_in),
    .out_valid   (out_valid),
    .alu_result  (alu_result),
    .st_val      (st_val),
    .dest        (dest),
    .wb_en       (wb_en),
    .mem_r_en    (mem_r_en),
    .mem_w_en    (mem_w_en),
    .status      (status)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic drive(input logic v, input logic [3:0] cmd,
                       input logic s, input logic wb,
                       input logic mr, input logic mw,
                       input logic [3:0] d,
                       input logic [31:0] a,
                       input logic [31:0] b,
                       input logic [31:0] sv);
    in_valid    = v;
    exe_cmd     = cmd;
    s_bit       = s;
    wb_en_in    = wb;
    mem_r_en_in = mr;
    mem_w_en_in = mw;
    dest_in     = d;
    val_1       = a;
    val_2       = b;
    st_val_in   = sv;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_valid"}, 32'(out_valid), 32'd0);
    chk({tag, "_res"}, alu_result, 32'd0);
    chk({tag, "_st"}, st_val, 32'd0);
    chk({tag, "_dest"}, 32'(dest), 32'd0);
    chk({tag, "_ctl"}, {29'd0, wb_en, mem_r_en, mem_w_en}, 32'd0);
    chk({tag, "_stat"}, 32'(status), 32'd0);
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    rst      = 1'b0;
    freeze   = 1'b0;
    flush    = 1'b0;
    drive(0, 4'd0, 0, 0, 0, 0, 4'd0, 32'd0, 32'd0, 32'd0);

    // async reset before any clock edge
    #2 rst = 1'b1;
    #1 chk_zero("rst_async");
    tick();
    rst = 1'b0;

    drive(1, 4'b0010, 1, 1, 0, 0, 4'd3, 32'h7FFF_FFFF, 32'd1, 32'd0);
    tick();
    chk("adds_res", alu_result, 32'h8000_0000);
    chk("adds_stat", 32'(status), 32'h9);
    chk("adds_valid", 32'(out_valid), 32'd1);
    chk("adds_wb", 32'(wb_en), 32'd1);
    chk("adds_dest", 32'(dest), 32'd3);

    drive(1, 4'b0100, 1, 1, 0, 0, 4'd1, 32'd5, 32'd5, 32'd0);
    tick();
    chk("subs_res", alu_result, 32'd0);
    chk("subs_stat", 32'(status), 32'h6);

    drive(1, 4'b0011, 0, 1, 0, 0, 4'd1, 32'd1, 32'd2, 32'd0);
    tick();
    chk("adc_res", alu_result, 32'd4);
    chk("adc_stat", 32'(status), 32'h6);

    drive(1, 4'b0010, 1, 1, 0, 0, 4'd1, 32'd1, 32'd1, 32'd0);
    tick();
    chk("adds2_stat", 32'(status), 32'h0);

    drive(1, 4'b0101, 0, 1, 0, 0, 4'd1, 32'd10, 32'd3, 32'd0);
    tick();
    chk("sbc_res", alu_result, 32'd6);

    drive(1, 4'b0010, 1, 1, 0, 0, 4'd1,
          32'h8000_0000, 32'h8000_0000, 32'd0);
    tick();
    chk("adds3_res", alu_result, 32'd0);
    chk("adds3_stat", 32'(status), 32'h7);

    drive(1, 4'b0110, 1, 1, 0, 0, 4'd1, 32'hF0, 32'hFF, 32'd0);
    tick();
    chk("ands1_res", alu_result, 32'hF0);
    chk("ands1_stat", 32'(status), 32'h3);

    drive(1, 4'b0110, 1, 1, 0, 0, 4'd1, 32'hF0, 32'h0F, 32'd0);
    tick();
    chk("ands2_res", alu_result, 32'd0);
    chk("ands2_stat", 32'(status), 32'h7);

    // bubble with s_bit set leaves flags and controls alone
    drive(0, 4'b0010, 1, 1, 1, 1, 4'd2, 32'd1, 32'd1, 32'd0);
    tick();
    chk("bub_valid", 32'(out_valid), 32'd0);
    chk("bub_ctl", {29'd0, wb_en, mem_r_en, mem_w_en}, 32'd0);
    chk("bub_stat", 32'(status), 32'h7);

    drive(1, 4'b0001, 0, 1, 0, 0, 4'd5, 32'd0, 32'h1234, 32'd0);
    tick();
    chk("mov_res", alu_result, 32'h1234);

    freeze = 1'b1;
    for (int i = 0; i < 3; i++) begin
      drive(1, 4'b0010, 1, 0, 1, 1, 4'(i + 8),
            32'(i + 100), 32'hFFFF_FFFF, 32'(i));
      tick();
      chk("frz_res", alu_result, 32'h1234);
      chk("frz_dest", 32'(dest), 32'd5);
      chk("frz_stat", 32'(status), 32'h7);
      chk("frz_ctl", {29'd0, wb_en, mem_r_en, mem_w_en}, 32'h4);
    end
    drive(1, 4'b1000, 1, 1, 0, 0, 4'd6, 32'hFF, 32'h0F, 32'd0);
    tick();
    chk("frz_hold2", alu_result, 32'h1234);
    freeze = 1'b0;
    tick();
    chk("rel_res", alu_result, 32'hF0);
    chk("rel_dest", 32'(dest), 32'd6);
    chk("rel_stat", 32'(status), 32'h3);

    flush = 1'b1;
    drive(1, 4'b0010, 1, 1, 0, 0, 4'd4, 32'd1, 32'd1, 32'd0);
    tick();
    flush = 1'b0;
    chk("fl_valid", 32'(out_valid), 32'd0);
    chk("fl_wb", 32'(wb_en), 32'd0);
    chk("fl_res", alu_result, 32'd0);
    chk("fl_stat", 32'(status), 32'h3);

    drive(1, 4'b0111, 0, 1, 0, 0, 4'd7, 32'hA0, 32'h05, 32'd0);
    tick();
    chk("orr_res", alu_result, 32'hA5);

    freeze = 1'b1;
    flush  = 1'b1;
    drive(1, 4'b0010, 1, 0, 0, 0, 4'd2, 32'd0, 32'd0, 32'd0);
    tick();
    freeze = 1'b0;
    flush  = 1'b0;
    chk("ff_res", alu_result, 32'hA5);
    chk("ff_valid", 32'(out_valid), 32'd1);
    chk("ff_wb", 32'(wb_en), 32'd1);
    chk("ff_dest", 32'(dest), 32'd7);
    chk("ff_stat", 32'(status), 32'h3);

    drive(1, 4'b0010, 0, 1, 1, 0, 4'd9, 32'h100, 32'd8, 32'd0);
    tick();
    chk("ldr_res", alu_result, 32'h108);
    chk("ldr_ctl", {29'd0, wb_en, mem_r_en, mem_w_en}, 32'h6);

    drive(1, 4'b0010, 0, 0, 0, 1, 4'd9, 32'h200, 32'd4, 32'hDEAD);
    tick();
    chk("str_res", alu_result, 32'h204);
    chk("str_st", st_val, 32'hDEAD);
    chk("str_ctl", {29'd0, wb_en, mem_r_en, mem_w_en}, 32'h1);

    drive(1, 4'b1001, 1, 1, 0, 0, 4'd1, 32'd0, 32'd0, 32'd0);
    tick();
    chk("mvn_res", alu_result, 32'hFFFF_FFFF);
    chk("mvn_stat", 32'(status), 32'hB);

    drive(1, 4'b1111, 1, 1, 0, 0, 4'd1, 32'd3, 32'd3, 32'd0);
    tick();
    chk("undef_res", alu_result, 32'd0);
    chk("undef_stat", 32'(status), 32'h7);

    // reset while frozen, mid-cycle
    freeze = 1'b1;
    #3 rst = 1'b1;
    #1 chk_zero("rst_frz");
    tick();
    rst    = 1'b0;
    freeze = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
